// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch controller.
// BCD helper used by the digit counters.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP
  } sw_state_t;

  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

  // Two-digit BCD increment without wrap handling
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX.
// carry_out flags the wrap cycle for chaining.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [7:0] cnt,
  output logic       carry_out
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign cnt       = cnt_q;
  assign carry_out = en && !clr && (cnt_q == MAX);

  // Next count: clear wins, otherwise step and wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == MAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = bcd_inc(cnt_q);
      end
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mm:ss.cc driven by 10 ms ticks
// derived from the msec digit, with button FSM.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int Q_W      = 4,
  parameter int Q_LAST   = 9,
  parameter int SYNC_STG = 2
) (
  input  logic           clk_4m,
  input  logic           rst,
  input  logic [Q_W-1:0] q_msec,
  input  logic           btn_ss,
  input  logic           btn_lap,
  input  logic           btn_clr,
  output logic [7:0]     cs_bcd,
  output logic [7:0]     sec_bcd,
  output logic [7:0]     min_bcd,
  output logic           running,
  output logic           lap_frozen,
  output logic           ovf
);

  localparam int B_SS  = 0;
  localparam int B_LAP = 1;
  localparam int B_CLR = 2;

  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;

  assign btn_raw = {btn_clr, btn_lap, btn_ss};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic [SYNC_STG-1:0] sync_q;
    logic [SYNC_STG-1:0] sync_d;
    logic                prev_q;
    logic                prev_d;

    // Shift the raw level in; remember last synced level
    always_comb begin
      sync_d = {sync_q[SYNC_STG-2:0], btn_raw[i]};
      prev_d = sync_q[SYNC_STG-1];
    end

    // Synchroniser and edge-detect flops
    always_ff @(posedge clk_4m or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        prev_q <= prev_d;
      end
    end

    assign btn_pulse[i] = sync_q[SYNC_STG-1] & ~prev_q;
  end

  wire ss_p  = btn_pulse[B_SS];
  wire lap_p = btn_pulse[B_LAP];
  wire clr_p = btn_pulse[B_CLR];

  logic [Q_W-1:0] q_prev_q;
  logic [Q_W-1:0] q_prev_d;
  logic           tick;

  // Track previous digit to spot the last->0 wrap
  always_comb begin
    q_prev_d = q_msec;
    tick     = (q_prev_q == Q_W'(Q_LAST))
            && (q_msec == '0);
  end

  // Previous-digit register
  always_ff @(posedge clk_4m or posedge rst) begin
    if (rst) begin
      q_prev_q <= '0;
    end else begin
      q_prev_q <= q_prev_d;
    end
  end

  sw_state_t state_q;
  sw_state_t state_d;

  // Next state: clear beats start/stop beats lap
  always_comb begin
    state_d = state_q;
    if (clr_p) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_p) state_d = RUN;
        end
        RUN: begin
          if (ss_p)       state_d = PAUSE;
          else if (lap_p) state_d = LAP;
        end
        LAP: begin
          if (ss_p)       state_d = PAUSE;
          else if (lap_p) state_d = RUN;
        end
        PAUSE: begin
          if (ss_p) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_4m or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  logic       live_run;
  logic       cs_en;
  logic       cs_co;
  logic       sec_co;
  logic       min_co;
  logic [7:0] cs_live;
  logic [7:0] sec_live;
  logic [7:0] min_live;

  assign live_run = (state_q == RUN)
                 || (state_q == LAP);
  assign cs_en    = live_run && tick;

  bcd_mod_counter #(.MAX(CS_MAX)) u_cs (
    .clk       (clk_4m),
    .rst       (rst),
    .en        (cs_en),
    .clr       (clr_p),
    .cnt       (cs_live),
    .carry_out (cs_co)
  );

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk       (clk_4m),
    .rst       (rst),
    .en        (cs_co),
    .clr       (clr_p),
    .cnt       (sec_live),
    .carry_out (sec_co)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk       (clk_4m),
    .rst       (rst),
    .en        (sec_co),
    .clr       (clr_p),
    .cnt       (min_live),
    .carry_out (min_co)
  );

  logic [23:0] disp_q;
  logic [23:0] disp_d;
  logic        ovf_q;
  logic        ovf_d;

  // Display tracks live time except while a lap is held
  always_comb begin
    disp_d = {min_live, sec_live, cs_live};
    if (clr_p) begin
      disp_d = '0;
    end else if (state_q == LAP && state_d == LAP) begin
      disp_d = disp_q;
    end
  end

  // Overflow is sticky until cleared
  always_comb begin
    ovf_d = ovf_q;
    if (clr_p) begin
      ovf_d = 1'b0;
    end else if (min_co) begin
      ovf_d = 1'b1;
    end
  end

  // Display and overflow registers
  always_ff @(posedge clk_4m or posedge rst) begin
    if (rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
    end
  end

  assign min_bcd    = disp_q[23:16];
  assign sec_bcd    = disp_q[15:8];
  assign cs_bcd     = disp_q[7:0];
  assign running    = live_run;
  assign lap_frozen = (state_q == LAP);
  assign ovf        = ovf_q;

endmodule
